// File: rtl/nrisc_pkg.sv
// Shared definitions for the 8-bit nrisc system.
//   NRISC_DATA_W / NRISC_ADDR_W : default byte and address widths
//   loader_state_t              : program loader FSM states
//   OP_HALT                     : opcode pattern that stops the core
package nrisc_pkg;

    localparam int NRISC_DATA_W = 8;
    localparam int NRISC_ADDR_W = 8;

    localparam logic [NRISC_DATA_W-1:0] OP_HALT = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
        ST_CHK,
        ST_DONE,
        ST_ERR
    } loader_state_t;

endpackage

// File: rtl/prog_loader.sv
// Byte-stream program loader. Accepts LEN, N data bytes and an XOR checksum
// byte from a valid/ready source, writes the data bytes into memory starting
// at BASE_ADDR, and releases the core from halt only once the image checks.
//
// Ports:
//   c          system clock, rising edge
//   rst        synchronous active-high reset
//   start      one-cycle load request (honoured in IDLE, DONE, ERR)
//   in_valid   source presents a byte on in_data
//   in_data    stream byte
//   in_ready   loader takes a byte this cycle (LEN, DATA, CHK)
//   mem_we     one-cycle memory write strobe
//   mem_addr   write address (wraps modulo 2^ADDR_W)
//   mem_wdata  write data
//   halt       registered core halt, low only while DONE
//   done       image loaded and verified
//   err        checksum mismatch
//   count      data bytes written in the current load
module prog_loader
    import nrisc_pkg::*;
#(
    parameter int                ADDR_W    = NRISC_ADDR_W,
    parameter int                DATA_W    = NRISC_DATA_W,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              c,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              halt,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] count
);

    loader_state_t     state;
    loader_state_t     state_nxt;
    logic [DATA_W-1:0] len_q;
    logic [DATA_W-1:0] acc_q;
    logic [ADDR_W-1:0] count_inc;
    logic              last_byte;
    logic              xfer;

    assign count_inc = count + 1'b1;
    // The byte being accepted now is the Nth one, so the FSM leaves DATA and
    // count can never step past N.
    assign last_byte = (count_inc == ADDR_W'(len_q));
    assign xfer      = in_valid && in_ready;

    assign done = (state == ST_DONE);
    assign err  = (state == ST_ERR);

    always_ff @(posedge c) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_LEN;
            end
            ST_LEN: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = (in_data == '0) ? ST_CHK : ST_DATA;
            end
            ST_DATA: begin
                in_ready = 1'b1;
                if (in_valid && last_byte) state_nxt = ST_CHK;
            end
            ST_CHK: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = (in_data == acc_q) ? ST_DONE : ST_ERR;
            end
            ST_DONE, ST_ERR: begin
                if (start) state_nxt = ST_LEN;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Write port, checksum and count. A reset on the same edge as a data
    // transfer wins, so no strobe is issued for that byte.
    always_ff @(posedge c) begin
        if (rst) begin
            mem_we    <= 1'b0;
            mem_addr  <= BASE_ADDR;
            mem_wdata <= '0;
            count     <= '0;
            acc_q     <= '0;
            len_q     <= '0;
            halt      <= 1'b1;
        end else begin
            mem_we <= 1'b0;
            // Lags DONE entry by one edge; a start in DONE re-halts at once.
            halt   <= (state != ST_DONE) || start;
            if (xfer) begin
                case (state)
                    ST_LEN: begin
                        len_q <= in_data;
                        count <= '0;
                        acc_q <= '0;
                    end
                    ST_DATA: begin
                        mem_we    <= 1'b1;
                        mem_addr  <= BASE_ADDR + count;
                        mem_wdata <= in_data;
                        acc_q     <= acc_q ^ in_data;
                        count     <= count_inc;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

    logic       c = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;

    logic       in_ready0, mem_we0, halt0, done0, err0;
    logic [7:0] mem_addr0, mem_wdata0, count0;
    logic       in_ready1, mem_we1, halt1, done1, err1;
    logic [7:0] mem_addr1, mem_wdata1, count1;

    int checks = 0;
    int errors = 0;

    always #5 c = ~c;

    prog_loader #(.ADDR_W(8), .DATA_W(8), .BASE_ADDR(8'h00)) dut0 (
        .c(c), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready0), .mem_we(mem_we0), .mem_addr(mem_addr0),
        .mem_wdata(mem_wdata0), .halt(halt0), .done(done0), .err(err0),
        .count(count0)
    );

    prog_loader #(.ADDR_W(8), .DATA_W(8), .BASE_ADDR(8'hFE)) dut1 (
        .c(c), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready1), .mem_we(mem_we1), .mem_addr(mem_addr1),
        .mem_wdata(mem_wdata1), .halt(halt1), .done(done1), .err(err1),
        .count(count1)
    );

    // Every cycle with a strobe is logged as {addr, data}.
    logic [15:0] wq0[$];
    logic [15:0] wq1[$];
    always @(negedge c) begin
        if (mem_we0) wq0.push_back({mem_addr0, mem_wdata0});
        if (mem_we1) wq1.push_back({mem_addr1, mem_wdata1});
    end

    logic [7:0] stream_q[$];

    typedef struct {
        string       name;
        logic [63:0] bytes;
        int          n;
        int          gap;
        logic        exp_done;
        logic        exp_err;
        logic [7:0]  exp_count;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp_v);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        logic ok;
        logic took;
        took = 1'b0;
        in_valid = 1'b0;
        repeat (gap) @(negedge c);
        in_valid = 1'b1;
        in_data  = b;
        for (int k = 0; k < 20 && !took; k++) begin
            ok = in_ready0;
            @(posedge c);
            took = ok;
            @(negedge c);
        end
        in_valid = 1'b0;
        if (!took) begin
            checks++;
            errors++;
            $display("FAIL send_byte timeout: byte 0x%0h never accepted", b);
        end
    endtask

    // Reference: writes are the N data bytes at (base+i) mod 256; image is good
    // when the trailing byte equals the XOR of the data bytes.
    task automatic run_load(input string name, input int gap, input logic exp_done,
                            input logic exp_err, input logic [7:0] exp_count);
        int         n;
        int         nw;
        int         base;
        int         g;
        logic [7:0] x;
        logic [15:0] w;
        wq0.delete();
        wq1.delete();
        start = 1'b1;
        @(negedge c);
        start = 1'b0;
        chk({name, "_start_halt"}, halt0, 1);
        chk({name, "_start_done"}, {done0, err0}, 0);
        chk({name, "_start_ready"}, in_ready0, 1);
        for (int k = 0; k < stream_q.size(); k++) begin
            g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            send_byte(stream_q[k], g);
        end
        chk({name, "_done"}, done0, exp_done);
        chk({name, "_err"}, err0, exp_err);
        chk({name, "_halt_lag"}, halt0, 1);
        @(negedge c);
        chk({name, "_halt"}, halt0, !exp_done);
        chk({name, "_count"}, count0, exp_count);
        chk({name, "_done_b"}, done1, exp_done);
        repeat (2) @(negedge c);
        n = stream_q[0];
        x = 8'h00;
        for (int i = 1; i <= n; i++) x ^= stream_q[i];
        chk({name, "_model_ok"}, exp_done, (x == stream_q[n + 1]));
        for (int d = 0; d < 2; d++) begin
            base = (d == 1) ? 'hFE : 0;
            nw   = (d == 1) ? wq1.size() : wq0.size();
            chk({name, "_nwr"}, nw, n);
            for (int i = 0; i < n && i < nw; i++) begin
                w = (d == 1) ? wq1[i] : wq0[i];
                chk({name, "_addr"}, w[15:8], (base + i) % 256);
                chk({name, "_data"}, w[7:0], stream_q[i + 1]);
            end
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n;
        logic [7:0] x;
        logic       bad;

        vecs[0] = '{"good",  64'h03A10213B0000000, 5, 0, 1'b1, 1'b0, 8'd3};
        vecs[1] = '{"badck", 64'h0255AA0000000000, 4, 0, 1'b0, 1'b1, 8'd2};
        vecs[2] = '{"reld",  64'h017E7E0000000000, 3, 0, 1'b1, 1'b0, 8'd1};
        vecs[3] = '{"empty", 64'h0000000000000000, 2, 0, 1'b1, 1'b0, 8'd0};
        vecs[4] = '{"bpres", 64'h03A10213B0000000, 5, 3, 1'b1, 1'b0, 8'd3};
        vecs[5] = '{"wrap",  64'h0311223300000000, 5, 1, 1'b1, 1'b0, 8'd3};

        // Reset state
        repeat (2) @(negedge c);
        chk("rst_halt", halt0, 1);
        chk("rst_done", done0, 0);
        chk("rst_err", err0, 0);
        chk("rst_we", mem_we0, 0);
        chk("rst_ready", in_ready0, 0);
        chk("rst_addr", mem_addr0, 8'h00);
        chk("rst_addr_b", mem_addr1, 8'hFE);
        chk("rst_wdata", mem_wdata0, 0);
        chk("rst_count", count0, 0);
        rst = 1'b0;
        @(negedge c);
        chk("idle_ready", in_ready0, 0);

        // Table-driven loads
        for (int v = 0; v < 6; v++) begin
            stream_q.delete();
            for (int k = 0; k < vecs[v].n; k++) stream_q.push_back(vecs[v].bytes[63 - 8*k -: 8]);
            run_load(vecs[v].name, vecs[v].gap, vecs[v].exp_done, vecs[v].exp_err,
                     vecs[v].exp_count);
        end

        // Randomized loads against the reference
        for (int r = 0; r < 20; r++) begin
            stream_q.delete();
            n = $urandom_range(0, 12);
            stream_q.push_back(8'(n));
            x = 8'h00;
            for (int i = 0; i < n; i++) begin
                stream_q.push_back(8'($urandom));
                x ^= stream_q[i + 1];
            end
            bad = ($urandom_range(0, 3) == 0);
            if (bad) x ^= 8'($urandom_range(1, 255));
            stream_q.push_back(x);
            run_load("rand", -1, !bad, bad, 8'(n));
        end

        // Reset in the middle of a load, colliding with a data transfer
        wq0.delete();
        wq1.delete();
        start = 1'b1;
        @(negedge c);
        start = 1'b0;
        send_byte(8'h04, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = 8'hCC;
        @(negedge c);
        chk("mid_rst_ready", in_ready0, 0);
        chk("mid_rst_halt", halt0, 1);
        chk("mid_rst_we", mem_we0, 0);
        chk("mid_rst_count", count0, 0);
        chk("mid_rst_done", done0, 0);
        chk("mid_rst_addr_b", mem_addr1, 8'hFE);
        rst = 1'b0;
        repeat (3) @(negedge c);
        in_valid = 1'b0;
        chk("mid_rst_idle_ready", in_ready0, 0);
        chk("mid_rst_nwr", wq0.size(), 2);
        chk("mid_rst_nwr_b", wq1.size(), 2);
        if (wq0.size() >= 2) begin
            chk("mid_rst_w0", wq0[0], 16'h00AA);
            chk("mid_rst_w1", wq0[1], 16'h01BB);
        end
        stream_q.delete();
        stream_q.push_back(8'h02);
        stream_q.push_back(8'h5A);
        stream_q.push_back(8'hA5);
        stream_q.push_back(8'hFF);
        run_load("after_rst", 0, 1'b1, 1'b0, 8'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
